// File: rtl/gal16v8_reg.sv
// GAL16V8 in registered mode: 8 OLMCs, each with an 8-term AND/OR array, polarity and a D flip-flop.
// The outputs are tri-stated by the common oe_n, and feedback always comes from the internal registers.
module gal16v8_reg #(
  parameter logic [2047:0] FUSES = {
    224'h0, 32'hFFFF_BFFF,
    224'h0, 32'hFFFF_EFFF,
    224'h0, 32'hFFFF_FBFF,
    224'h0, 32'hFFFF_FEFF,
    224'h0, 32'hFFFF_FFBF,
    224'h0, 32'hFFFF_FFEF,
    224'h0, 32'hFFFF_FFFB,
    224'h0, 32'hFFFF_FFFE
  },
  parameter logic [7:0]    POL   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  input  logic       oe_n,
  inout  wire  [7:0] io
);

  logic [7:0]  q;
  logic [7:0]  d;
  logic [15:0] s;
  logic [31:0] cols;
  logic        term_or;

  // Each term uses a fuse value of 1 to turn its column into a don't-care, so the term is the AND of (fuse | column).
  always_comb begin
    s       = {q, in};
    cols    = '0;
    d       = '0;
    term_or = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cols[2*k]   = s[k];
      cols[2*k+1] = ~s[k];
    end
    for (int i = 0; i < 8; i++) begin
      term_or = 1'b0;
      for (int t = 0; t < 8; t++) begin
        term_or = term_or | (&(FUSES[(i*8+t)*32 +: 32] | cols));
      end
      d[i] = POL[i] ? term_or : ~term_or;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

  assign io = oe_n ? 8'bz : q;

endmodule

// File: tb/tb_gal16v8_reg.sv
// Bench for gal16v8_reg: one pass-through instance and two custom fuse maps (a toggle bit, a constant-1 term, and a term that never asserts).
// It runs directed steps and then random traffic, and checks every instance against a rule-level model.
module tb_gal16v8_reg;

  localparam logic [255:0] PASS3 = {224'h0, 32'hFFFF_FFBF};
  localparam logic [255:0] PASS4 = {224'h0, 32'hFFFF_FEFF};
  localparam logic [255:0] PASS5 = {224'h0, 32'hFFFF_FBFF};
  localparam logic [255:0] PASS6 = {224'h0, 32'hFFFF_EFFF};
  localparam logic [255:0] PASS7 = {224'h0, 32'hFFFF_BFFF};
  // OLMC0 uses ~q[0] only, OLMC1 has all fuses open, and OLMC2 connects both in[1] and ~in[1].
  localparam logic [2047:0] CUST = {
    PASS7, PASS6, PASS5, PASS4, PASS3,
    224'h0, 32'hFFFF_FFF3,
    224'h0, 32'hFFFF_FFFF,
    224'h0, 32'hFFFD_FFFF
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in;
  logic       oe_n;
  wire  [7:0] io_d;
  wire  [7:0] io_c;
  wire  [7:0] io_p;

  logic [7:0] exp_d;
  logic [7:0] exp_c;
  logic [7:0] exp_p;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  gal16v8_reg dut_d (.clk(clk), .rst_n(rst_n), .in(in), .oe_n(oe_n), .io(io_d));
  gal16v8_reg #(.FUSES(CUST), .POL(8'hFF)) dut_c (.clk(clk), .rst_n(rst_n), .in(in), .oe_n(oe_n), .io(io_c));
  gal16v8_reg #(.FUSES(CUST), .POL(8'hFD)) dut_p (.clk(clk), .rst_n(rst_n), .in(in), .oe_n(oe_n), .io(io_p));

  task automatic applyStimulus();
    @(posedge clk);
    if (!rst_n) begin
      exp_d = 8'h00;
      exp_c = 8'h00;
      exp_p = 8'h00;
    end else begin
      exp_d = in;
      exp_c = {in[7:3], 1'b0, 1'b1, ~exp_c[0]};
      exp_p = {in[7:3], 1'b0, 1'b0, ~exp_p[0]};
    end
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] want_d;
    logic [7:0] want_c;
    logic [7:0] want_p;
    want_d = oe_n ? 8'bz : exp_d;
    want_c = oe_n ? 8'bz : exp_c;
    want_p = oe_n ? 8'bz : exp_p;
    checks++;
    assert (io_d === want_d) else begin
      errors++;
      $error("[TB] FAIL %s io_d observed=%h expected=%h", tag, io_d, want_d);
    end
    checks++;
    assert (io_c === want_c) else begin
      errors++;
      $error("[TB] FAIL %s io_c observed=%h expected=%h", tag, io_c, want_c);
    end
    checks++;
    assert (io_p === want_p) else begin
      errors++;
      $error("[TB] FAIL %s io_p observed=%h expected=%h", tag, io_p, want_p);
    end
  endtask

  initial begin
    logic [7:0] seq [5];
    seq[0] = 8'h0C; seq[1] = 8'h09; seq[2] = 8'h06; seq[3] = 8'h03; seq[4] = 8'h0C;
    exp_d = 8'h00;
    exp_c = 8'h00;
    exp_p = 8'h00;
    rst_n = 1'b0;
    oe_n  = 1'b0;
    in    = 8'hA5;
    applyStimulus();
    checkOutput("reset");
    rst_n = 1'b1;

    foreach (seq[j]) begin
      in = seq[j];
      applyStimulus();
      checkOutput("pipeline");
    end
    applyStimulus();
    checkOutput("hold1");
    applyStimulus();
    checkOutput("hold2");

    in = 8'h33;
    #2;
    checkOutput("mid_cycle");
    applyStimulus();
    checkOutput("next_edge");

    oe_n = 1'b1;
    #1;
    checkOutput("oe_off");
    in = 8'h05;
    applyStimulus();
    checkOutput("tristate_update");
    oe_n = 1'b0;
    #1;
    checkOutput("oe_on");

    rst_n = 1'b0;
    in    = 8'hFF;
    applyStimulus();
    checkOutput("reset_ff");
    oe_n = 1'b1;
    applyStimulus();
    checkOutput("reset_z");
    oe_n  = 1'b0;
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("release");

    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in = 8'(j * 37);
      applyStimulus();
      checkOutput("toggle");
    end

    for (int j = 0; j < 200; j++) begin
      in    = 8'($urandom);
      oe_n  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 15) != 0);
      applyStimulus();
      checkOutput("random");
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
